// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants and helpers for the pipeline performance counter
package perf_pkg;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   localparam int CH_STALL   = 0;
   localparam int CH_FLUSH   = 1;
   localparam int CH_RETIRE  = 2;
   localparam int CH_LOADUSE = 3;

   // Selector must reach NUM_CH itself, which addresses the cycle snapshot.
   function automatic int sel_w(input int num_ch);
      return $clog2(num_ch + 1);
   endfunction

endpackage

// File: rtl/perf_ctr_cell.sv
// rtl/perf_ctr_cell.sv - one event counter with clear, saturate/wrap mode and sticky overflow
module perf_ctr_cell
   import perf_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic         sat_i,
   output logic [W-1:0] cnt_o,
   output logic         ovf_o
);

   logic [W-1:0] r_cnt;
   logic         r_ovf;
   logic         w_at_max;

   assign w_at_max = &r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (inc_i) begin
         if (w_at_max) begin
            r_ovf <= 1'b1;
            r_cnt <= (sat_i == MODE_SAT) ? r_cnt : '0;
         end else begin
            r_cnt <= r_cnt + W'(1);
         end
      end
   end

   assign cnt_o = r_cnt;
   assign ovf_o = r_ovf;

endmodule

// File: rtl/pipeline_perf_counter.sv
// rtl/pipeline_perf_counter.sv - cycle/event monitor with run limit, freeze, snapshot and readout
module pipeline_perf_counter
   import perf_pkg::*;
#(
   parameter int   NUM_CH   = 4,
   parameter int   CNT_W    = 32,
   parameter int   CYC_W    = 32,
   parameter bit   SATURATE = 1'b1,
   localparam int  SEL_W    = sel_w(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              freeze_i,
   input  logic              clear_i,
   input  logic              snap_i,
   input  logic [NUM_CH-1:0] event_i,
   input  logic [CYC_W-1:0]  limit_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic [CYC_W-1:0]  cycle_o,
   output logic [NUM_CH-1:0] ovf_o,
   output logic              done_o,
   output logic              snap_valid_o
);

   logic              w_active;
   logic              w_limit_on;
   logic              w_limit_hit_pre;
   logic              w_inc;
   logic [CYC_W-1:0]  w_cyc;
   logic [CYC_W-1:0]  w_cyc_next;
   logic              w_cyc_ovf_unused;
   logic [CNT_W-1:0]  w_cnt [NUM_CH];
   logic [CNT_W-1:0]  w_cyc_rd;
   logic [CNT_W-1:0]  w_rd_mux;

   logic              r_done;
   logic [CNT_W-1:0]  r_snap [NUM_CH];
   logic [CYC_W-1:0]  r_snap_cyc;
   logic              r_snap_valid;
   logic [CNT_W-1:0]  r_rd_data;

   // A limit already met (e.g. lowered mid-run) ends the run without another increment.
   assign w_active        = start_i & ~freeze_i & ~r_done;
   assign w_limit_on      = (limit_i != '0);
   assign w_limit_hit_pre = w_limit_on && (w_cyc >= limit_i);
   assign w_inc           = w_active & ~w_limit_hit_pre;
   assign w_cyc_next      = (&w_cyc) ? (SATURATE ? w_cyc : '0) : w_cyc + CYC_W'(1);

   perf_ctr_cell #(.W(CYC_W)) u_cyc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (w_inc),
      .sat_i (SATURATE),
      .cnt_o (w_cyc),
      .ovf_o (w_cyc_ovf_unused)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      perf_ctr_cell #(.W(CNT_W)) u_ch (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clear_i),
         .inc_i (w_inc & event_i[g]),
         .sat_i (SATURATE),
         .cnt_o (w_cnt[g]),
         .ovf_o (ovf_o[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_done <= 1'b0;
      end else if (w_active && w_limit_on && (w_limit_hit_pre || (w_cyc_next >= limit_i))) begin
         r_done <= 1'b1;
      end
   end

   if (CNT_W > CYC_W) begin : g_cyc_ext
      assign w_cyc_rd = {{(CNT_W-CYC_W){1'b0}}, r_snap_cyc};
   end else begin : g_cyc_trunc
      assign w_cyc_rd = r_snap_cyc[CNT_W-1:0];
   end

   always_comb begin
      w_rd_mux = '0;
      if (rd_sel_i == SEL_W'(NUM_CH)) begin
         w_rd_mux = w_cyc_rd;
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_sel_i == SEL_W'(k)) begin
            w_rd_mux = r_snap[k];
         end
      end
   end

   // Snapshot sees pre-edge live values, so a same-edge clear does not reach it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_snap[k] <= '0;
         end
         r_snap_cyc   <= '0;
         r_snap_valid <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         if (snap_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
               r_snap[k] <= w_cnt[k];
            end
            r_snap_cyc   <= w_cyc;
            r_snap_valid <= 1'b1;
         end
         r_rd_data <= w_rd_mux;
      end
   end

   assign rd_data_o    = r_rd_data;
   assign cycle_o      = w_cyc;
   assign done_o       = r_done;
   assign snap_valid_o = r_snap_valid;

endmodule
